// File: rtl/matrix_mult.sv
// Single-precision 4x4 matrix-vector multiplier on an FSL coprocessor port.
// The design uses one multiplier and one adder, each followed by one register stage, and returns y = M*v.
module matrix_mult (
    input  logic        FSL_Clk,
    input  logic        FSL_Rst,
    input  logic        FSL_S_Clk,
    output logic        FSL_S_Read,
    input  logic [31:0] FSL_S_Data,
    input  logic        FSL_S_Control,
    input  logic        FSL_S_Exists,
    input  logic        FSL_M_Clk,
    output logic        FSL_M_Write,
    output logic [31:0] FSL_M_Data,
    output logic        FSL_M_Control,
    input  logic        FSL_M_Full
);

    typedef enum logic [1:0] {ST_LOAD, ST_DRAIN, ST_SEND} state_t;

    state_t      r_state, w_stateNext;
    logic [4:0]  r_cnt;
    logic [31:0] r_mat, r_vec, r_prod, r_acc;
    logic [31:0] r_y [4];
    logic        r_vecValid, r_prodValid, r_drainCnt;
    logic [3:0]  r_vecTag, r_prodTag;
    logic [1:0]  r_idx;
    logic [31:0] w_prod, w_sum;
    logic        w_unused;

    // Flush-to-zero RNE multiply; denormal inputs and underflowing results become signed zero.
    function automatic logic [31:0] fpMul(input logic [31:0] a, input logic [31:0] b);
        logic              s, g, st;
        logic [47:0]       p;
        logic [22:0]       fr;
        logic [23:0]       rs;
        logic signed [9:0] e;
        s = a[31] ^ b[31];
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (p[47]) begin
            fr = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 10'sd1;
        end else begin
            fr = p[45:23]; g = p[22]; st = |p[21:0];
        end
        rs = {1'b0, fr} + {23'd0, g & (st | fr[0])};
        if (rs[23]) e = e + 10'sd1;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 10'sd0) return {s, 31'd0};
        if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
        return {s, e[7:0], rs[22:0]};
    endfunction

    // Flush-to-zero RNE add using guard, round and sticky bits; exact cancellation yields +0.
    function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       aa, bb, x, y;
        logic [26:0]       mx, my, n, tmp;
        logic [7:0]        d;
        logic [4:0]        sh, lz;
        logic [57:0]       wide;
        logic [27:0]       r;
        logic [23:0]       rs;
        logic              found, g, st;
        logic signed [9:0] e;
        aa = (a[30:23] == 8'd0) ? {a[31], 31'd0} : a;
        bb = (b[30:23] == 8'd0) ? {b[31], 31'd0} : b;
        if (bb[30:0] > aa[30:0]) begin x = bb; y = aa; end
        else begin x = aa; y = bb; end
        if (x[30:23] == 8'd0) return {x[31] & y[31], 31'd0};
        mx   = {1'b1, x[22:0], 3'b000};
        my   = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
        d    = x[30:23] - y[30:23];
        sh   = (d > 8'd31) ? 5'd31 : d[4:0];
        wide = {my, 31'd0} >> sh;
        if (x[31] == y[31]) r = {1'b0, mx} + {1'b0, wide[57:32], wide[31] | (|wide[30:0])};
        else                r = {1'b0, mx} - {1'b0, wide[57:32], wide[31] | (|wide[30:0])};
        e = $signed({2'b00, x[30:23]});
        lz = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && r[i]) begin
                lz = 5'(26 - i);
                found = 1'b1;
            end
        end
        if (r[27]) begin
            n = {r[27:2], r[1] | r[0]};
            e = e + 10'sd1;
        end else begin
            tmp = r[26:0] << lz;
            n = tmp;
            e = e - $signed({5'd0, lz});
        end
        if (!n[26]) return 32'd0;
        g  = n[2];
        st = n[1] | n[0];
        rs = {1'b0, n[25:3]} + {23'd0, g & (st | n[3])};
        if (rs[23]) e = e + 10'sd1;
        if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
        if (e <= 10'sd0) return {x[31], 31'd0};
        return {x[31], e[7:0], rs[22:0]};
    endfunction

    assign w_prod        = fpMul(r_mat, r_vec);
    assign w_sum         = fpAdd(r_acc, r_prod);
    assign FSL_M_Control = 1'b0;
    assign w_unused      = FSL_S_Clk ^ FSL_S_Control ^ FSL_M_Clk;

    always_ff @(posedge FSL_Clk) begin
        if (!FSL_Rst) r_state <= ST_LOAD;
        else          r_state <= w_stateNext;
    end

    // The handshake strobes are combinational and are held off for the whole reset cycle.
    always_comb begin
        w_stateNext = r_state;
        FSL_S_Read  = 1'b0;
        FSL_M_Write = 1'b0;
        FSL_M_Data  = 32'd0;
        case (r_state)
            ST_LOAD: begin
                FSL_S_Read = FSL_Rst & FSL_S_Exists;
                if (FSL_S_Read && r_cnt == 5'd31) w_stateNext = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_drainCnt) w_stateNext = ST_SEND;
            end
            ST_SEND: begin
                FSL_M_Write = FSL_Rst & ~FSL_M_Full;
                FSL_M_Data  = FSL_Rst ? r_y[r_idx] : 32'd0;
                if (FSL_M_Write && r_idx == 2'd3) w_stateNext = ST_LOAD;
            end
            default: w_stateNext = ST_LOAD;
        endcase
    end

    // Each tag holds {row, column} and travels with the vector word through the multiply and accumulate stages.
    always_ff @(posedge FSL_Clk) begin
        if (!FSL_Rst) begin
            r_cnt       <= 5'd0;
            r_mat       <= 32'd0;
            r_vec       <= 32'd0;
            r_prod      <= 32'd0;
            r_acc       <= 32'd0;
            r_vecValid  <= 1'b0;
            r_prodValid <= 1'b0;
            r_vecTag    <= 4'd0;
            r_prodTag   <= 4'd0;
            r_drainCnt  <= 1'b0;
            r_idx       <= 2'd0;
            for (int i = 0; i < 4; i++) r_y[i] <= 32'd0;
        end else begin
            r_vecValid  <= 1'b0;
            r_prodValid <= r_vecValid;
            r_drainCnt  <= (r_state == ST_DRAIN) ? ~r_drainCnt : 1'b0;
            if (FSL_S_Read) begin
                r_cnt <= r_cnt + 5'd1;
                if (!r_cnt[0]) begin
                    r_mat <= FSL_S_Data;
                end else begin
                    r_vec      <= FSL_S_Data;
                    r_vecValid <= 1'b1;
                    r_vecTag   <= r_cnt[4:1];
                end
            end
            if (r_vecValid) begin
                r_prod    <= w_prod;
                r_prodTag <= r_vecTag;
            end
            if (r_prodValid) begin
                if (r_prodTag[1:0] == 2'd3) begin
                    r_y[r_prodTag[3:2]] <= w_sum;
                    r_acc <= 32'd0;
                end else begin
                    r_acc <= w_sum;
                end
            end
            if (FSL_M_Write) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_cnt <= 5'd0;
                    r_acc <= 32'd0;
                    for (int i = 0; i < 4; i++) r_y[i] <= 32'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_mult.sv
// Self-checking bench for matrix_mult. It drives a table of jobs plus corner-case sequences.
// Expected results come from a double-precision model that rounds each step back to single precision.
module tb_matrix_mult;

    logic        FSL_Clk = 1'b0;
    logic        FSL_Rst = 1'b0;
    logic        FSL_S_Read;
    logic [31:0] FSL_S_Data = 32'd0;
    logic        FSL_S_Control = 1'b0;
    logic        FSL_S_Exists = 1'b0;
    logic        FSL_M_Write;
    logic [31:0] FSL_M_Data;
    logic        FSL_M_Control;
    logic        FSL_M_Full = 1'b0;

    int total = 0;
    int bad   = 0;
    int outCount = 0;
    logic [31:0] expQ [$];

    typedef struct packed {
        logic [15:0][31:0] mat;
        logic [3:0][31:0]  vec;
        logic [3:0][31:0]  expd;
    } job_t;

    job_t jobs [4];

    real nomM [16] = '{10.3, 6.25, 5.3, 0.0125, 3.5, 4.75, 9.1, 150.3,
                       -0.53, 12.1, -14.57, 3.01, 0.0125, 5.3, 6.25, 10.3};
    real nomV [4]  = '{-0.53, 12.1, -14.57, 3.01};
    real mixM [16] = '{1.0, -1.0, 1.0e-20, 0.0, -2.5, 1.0e-7, 1.0e20, -1.0,
                       1.0e10, 1.0, 3.3, 1.0e-3, -1.0, -1.0, -1.0, -1.0};
    real mixV [4]  = '{3.0, 3.0, 1.0e-20, 7.25};

    always #5 FSL_Clk = ~FSL_Clk;

    matrix_mult dut (
        .FSL_Clk       (FSL_Clk),
        .FSL_Rst       (FSL_Rst),
        .FSL_S_Clk     (FSL_Clk),
        .FSL_S_Read    (FSL_S_Read),
        .FSL_S_Data    (FSL_S_Data),
        .FSL_S_Control (FSL_S_Control),
        .FSL_S_Exists  (FSL_S_Exists),
        .FSL_M_Clk     (FSL_Clk),
        .FSL_M_Write   (FSL_M_Write),
        .FSL_M_Data    (FSL_M_Data),
        .FSL_M_Control (FSL_M_Control),
        .FSL_M_Full    (FSL_M_Full)
    );

    // Round a double to single with RNE. Results below the normal range flush to signed zero.
    function automatic logic [31:0] toSingle(input real x);
        logic [63:0] d;
        logic [24:0] m;
        logic        rnd;
        int          e;
        d = $realtobits(x);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e   = int'(d[62:52]) - 1023 + 127;
        rnd = d[28] & ((|d[27:0]) | d[29]);
        m   = {2'b01, d[51:29]} + {24'd0, rnd};
        if (m[24]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0) return {d[63], 31'd0};
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic real toReal(input logic [31:0] b);
        logic [10:0] de;
        if (b[30:23] == 8'd0) return $bitstoreal({b[31], 63'd0});
        de = 11'(int'(b[30:23]) + 896);
        return $bitstoreal({b[31], de, b[22:0], 29'd0});
    endfunction

    function automatic job_t addModel(input job_t j);
        logic [31:0] acc, p;
        for (int r = 0; r < 4; r++) begin
            acc = 32'd0;
            for (int k = 0; k < 4; k++) begin
                p   = toSingle(toReal(j.mat[r*4+k]) * toReal(j.vec[k]));
                acc = toSingle(toReal(acc) + toReal(p));
            end
            j.expd[r] = acc;
        end
        return j;
    endfunction

    function automatic logic [31:0] wordOf(input job_t j, input int i);
        int row, k;
        row = i / 8;
        k   = (i % 8) / 2;
        if (i % 2 == 1) return j.vec[k];
        return j.mat[row*4+k];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Feed nWords of a job. When gaps is set, Exists toggles every cycle. A word is counted as accepted when Read is high at the edge.
    task automatic applyStimulus(input job_t j, input int nWords, input bit gaps, input bit pushExp);
        int  i = 0;
        int  stall = 0;
        bit  tog = 1'b1;
        bit  accepted;
        if (pushExp) for (int k = 0; k < 4; k++) expQ.push_back(j.expd[k]);
        while (i < nWords) begin
            FSL_S_Data   = wordOf(j, i);
            FSL_S_Exists = gaps ? tog : 1'b1;
            tog = ~tog;
            @(negedge FSL_Clk);
            accepted = FSL_S_Read;
            if (gaps) checkOutput("readMirror", 32'(FSL_S_Read), 32'(FSL_S_Exists));
            @(posedge FSL_Clk);
            #1;
            if (accepted) i++;
            else begin
                stall++;
                if (stall > 300) begin
                    checkOutput("inputTimeout", 32'(i), 32'(nWords));
                    break;
                end
            end
        end
        FSL_S_Exists = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge FSL_Clk);
            n++;
        end
        if (expQ.size() != 0) checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
        @(posedge FSL_Clk);
        #1;
    endtask

    task automatic waitFirstWrite(output int n);
        n = 0;
        while (n < 30) begin
            @(negedge FSL_Clk);
            if (FSL_M_Write === 1'b1) break;
            n++;
        end
    endtask

    // The scoreboard pops one expected word each time the DUT writes at the following edge.
    always @(negedge FSL_Clk) begin
        if (FSL_M_Write === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedWrite: got %h, expected no write", FSL_M_Data);
            end else begin
                checkOutput($sformatf("result%0d", outCount), FSL_M_Data, expQ.pop_front());
                checkOutput("mControl", 32'(FSL_M_Control), 32'd0);
            end
            outCount++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        for (int k = 0; k < 16; k++) begin
            jobs[0].mat[k] = toSingle(nomM[k]);
            jobs[1].mat[k] = (k % 5 == 0) ? 32'h3F800000 : 32'd0;
            jobs[2].mat[k] = 32'd0;
            jobs[3].mat[k] = toSingle(mixM[k]);
        end
        for (int k = 0; k < 4; k++) begin
            jobs[0].vec[k] = toSingle(nomV[k]);
            jobs[1].vec[k] = toSingle(real'(k + 1));
            jobs[2].vec[k] = toSingle(nomV[k]);
            jobs[3].vec[k] = toSingle(mixV[k]);
            jobs[2].expd[k] = 32'd0;
        end
        jobs[0] = addModel(jobs[0]);
        jobs[3] = addModel(jobs[3]);
        jobs[1].expd[0] = 32'h3F800000;
        jobs[1].expd[1] = 32'h40000000;
        jobs[1].expd[2] = 32'h40400000;
        jobs[1].expd[3] = 32'h40800000;

        $display("[TB] reset checks");
        FSL_S_Exists = 1'b1;
        repeat (2) begin
            @(negedge FSL_Clk);
            checkOutput("rstRead", 32'(FSL_S_Read), 32'd0);
            checkOutput("rstWrite", 32'(FSL_M_Write), 32'd0);
            checkOutput("rstData", FSL_M_Data, 32'd0);
            checkOutput("rstControl", 32'(FSL_M_Control), 32'd0);
        end
        @(posedge FSL_Clk);
        #1;
        FSL_S_Exists = 1'b0;
        FSL_Rst = 1'b1;

        $display("[TB] table jobs");
        for (int t = 0; t < 4; t++) begin
            applyStimulus(jobs[t], 32, 1'b0, 1'b1);
            waitFirstWrite(n);
            checkOutput($sformatf("latency%0d", t), 32'(n), 32'd2);
            waitIdle();
        end

        $display("[TB] backpressure");
        applyStimulus(jobs[0], 32, 1'b0, 1'b1);
        waitFirstWrite(n);
        @(posedge FSL_Clk);
        #1;
        FSL_M_Full = 1'b1;
        repeat (2) begin
            @(negedge FSL_Clk);
            checkOutput("stallWrite", 32'(FSL_M_Write), 32'd0);
            checkOutput("stallData", FSL_M_Data, jobs[0].expd[1]);
        end
        @(posedge FSL_Clk);
        #1;
        FSL_M_Full = 1'b0;
        waitIdle();

        $display("[TB] input gaps");
        applyStimulus(jobs[0], 32, 1'b1, 1'b1);
        waitIdle();

        $display("[TB] reset during load");
        applyStimulus(jobs[0], 13, 1'b0, 1'b0);
        FSL_Rst = 1'b0;
        FSL_S_Exists = 1'b1;
        @(negedge FSL_Clk);
        checkOutput("midRstRead", 32'(FSL_S_Read), 32'd0);
        checkOutput("midRstWrite", 32'(FSL_M_Write), 32'd0);
        checkOutput("midRstData", FSL_M_Data, 32'd0);
        @(posedge FSL_Clk);
        #1;
        FSL_Rst = 1'b1;
        FSL_S_Exists = 1'b0;
        applyStimulus(jobs[1], 32, 1'b0, 1'b1);
        waitIdle();

        $display("[TB] reset during send");
        applyStimulus(jobs[3], 32, 1'b0, 1'b1);
        waitFirstWrite(n);
        @(posedge FSL_Clk);
        #1;
        FSL_Rst = 1'b0;
        @(negedge FSL_Clk);
        checkOutput("sendRstWrite", 32'(FSL_M_Write), 32'd0);
        checkOutput("sendRstData", FSL_M_Data, 32'd0);
        @(posedge FSL_Clk);
        #1;
        expQ.delete();
        FSL_Rst = 1'b1;
        applyStimulus(jobs[1], 32, 1'b0, 1'b1);
        waitIdle();

        $display("[TB] back-to-back jobs");
        applyStimulus(jobs[2], 32, 1'b0, 1'b1);
        applyStimulus(jobs[0], 32, 1'b0, 1'b1);
        waitIdle();
        repeat (5) @(posedge FSL_Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
